// File: rtl/rc4_pkg.sv
// Shared constants and types for the RC4 plaintext checker.
package rc4_pkg;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    localparam int DEF_MSG_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } chk_state_e;

endpackage

// File: rtl/rc4_msg_checker_if.sv
// Control and decrypt-memory read bus between the key controller and the checker.
interface rc4_msg_checker_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_q;
    logic              busy;
    logic              done;
    logic              msg_valid;
    logic [ADDR_W-1:0] bad_index;
    logic [7:0]        bad_char;

    modport slave (
        input  start, mem_q,
        output mem_address, busy, done, msg_valid, bad_index, bad_char
    );

    modport master (
        output start, mem_q,
        input  mem_address, busy, done, msg_valid, bad_index, bad_char
    );
endinterface

// File: rtl/rc4_char_is_legal.sv
// Plaintext byte classifier: lowercase a..z; space also legal when RC4_CHECK_SPACE_EN is defined.
module rc4_char_is_legal
    import rc4_pkg::*;
(
    input  logic [7:0] ch,
    output logic       legal
);

    logic is_lower;

    assign is_lower = (ch >= CHAR_LO) && (ch <= CHAR_HI);

`ifdef RC4_CHECK_SPACE_EN
    assign legal = is_lower || (ch == CHAR_SPACE);
`else
    assign legal = is_lower;
`endif

endmodule

// File: rtl/rc4_msg_checker.sv
// Scans the decrypt memory after decryption and reports pass/fail plus first bad byte.
// Optional space acceptance is selected by RC4_CHECK_SPACE_EN (see rc4_char_is_legal).
module rc4_msg_checker
    import rc4_pkg::*;
#(
    parameter int MSG_LEN      = DEF_MSG_LEN,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic              inclk,
    input  logic              reset_n,
    rc4_msg_checker_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    chk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              issued_all_q, issued_all_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              msg_valid_q, msg_valid_d;
    logic [ADDR_W-1:0] bad_index_q, bad_index_d;
    logic [7:0]        bad_char_q, bad_char_d;

    // Tag pipeline: stage 0 is the address being presented now, stage READ_LATENCY
    // lines up with the byte currently on mem_q.
    logic [READ_LATENCY-1:0]             vld_q, vld_d;
    logic [READ_LATENCY-1:0][ADDR_W-1:0] idx_q, idx_d;
    logic [READ_LATENCY:0]               vld_pipe;
    logic [READ_LATENCY:0][ADDR_W-1:0]   idx_pipe;

    logic issue;
    logic q_legal;

    assign issue       = (state_q == ST_SCAN) && !issued_all_q;
    assign vld_pipe[0] = issue;
    assign idx_pipe[0] = mem_address_q;

    for (genvar s = 1; s <= READ_LATENCY; s++) begin : g_pipe
        assign vld_pipe[s] = vld_q[s-1];
        assign idx_pipe[s] = idx_q[s-1];
    end

    rc4_char_is_legal u_cls (
        .ch    (bus.mem_q),
        .legal (q_legal)
    );

    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        issued_all_d  = issued_all_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        msg_valid_d   = msg_valid_q;
        bad_index_d   = bad_index_q;
        bad_char_d    = bad_char_q;
        for (int s = 0; s < READ_LATENCY; s++) begin
            vld_d[s] = vld_pipe[s];
            idx_d[s] = idx_pipe[s];
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = ST_SCAN;
                    mem_address_d = '0;
                    issued_all_d  = 1'b0;
                    busy_d        = 1'b1;
                    msg_valid_d   = 1'b0;
                    bad_index_d   = '0;
                    bad_char_d    = '0;
                    vld_d         = '0;
                end
            end
            ST_SCAN: begin
                if (!issued_all_q) begin
                    if (mem_address_q == LAST_IDX) issued_all_d  = 1'b1;
                    else                           mem_address_d = mem_address_q + 1'b1;
                end
                if (vld_pipe[READ_LATENCY]) begin
                    if (!q_legal) begin
                        msg_valid_d = 1'b0;
                        bad_index_d = idx_pipe[READ_LATENCY];
                        bad_char_d  = bus.mem_q;
                        vld_d       = '0;
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                    end else if (idx_pipe[READ_LATENCY] == LAST_IDX) begin
                        msg_valid_d = 1'b1;
                        vld_d       = '0;
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mem_address_q <= '0;
            issued_all_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            msg_valid_q   <= 1'b0;
            bad_index_q   <= '0;
            bad_char_q    <= '0;
            vld_q         <= '0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            issued_all_q  <= issued_all_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            msg_valid_q   <= msg_valid_d;
            bad_index_q   <= bad_index_d;
            bad_char_q    <= bad_char_d;
            vld_q         <= vld_d;
            idx_q         <= idx_d;
        end
    end

    assign bus.mem_address = mem_address_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.msg_valid   = msg_valid_q;
    assign bus.bad_index   = bad_index_q;
    assign bus.bad_char    = bad_char_q;

endmodule
